ahbl_arbiter_2: RTL

//  Two-master AHB-Lite arbiter: shares the single AHB-Lite slave path (splitter + slaves) between master ports M0, M1.

---
 rtl/ahbl_arbiter_2.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/ahbl_arbiter_2.sv
// ahbl_arbiter_2 - two-master AHB-Lite arbiter in front of a single slave path.
// Masters have no request/grant wires: a non-granted master's address phase is
// captured into a per-master pending slot, replayed when that master is granted,
// and the master is held in its data phase until the replayed transfer completes.
// Optional build macro AHBL_ARB_RR_EN selects round-robin arbitration; without it
// M0 has fixed priority over M1.
module ahbl_arbiter_2 (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] M0_HADDR,
    input  logic [1:0]  M0_HTRANS,
    input  logic [2:0]  M0_HSIZE,
    input  logic        M0_HWRITE,
    input  logic [31:0] M0_HWDATA,
    output logic        M0_HREADY,
    output logic [31:0] M0_HRDATA,
    input  logic [31:0] M1_HADDR,
    input  logic [1:0]  M1_HTRANS,
    input  logic [2:0]  M1_HSIZE,
    input  logic        M1_HWRITE,
    input  logic [31:0] M1_HWDATA,
    output logic        M1_HREADY,
    output logic [31:0] M1_HRDATA,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    // Per-master views of the live master signals, indexed by master number.
    logic [1:0][31:0] m_haddr;
    logic [1:0][1:0]  m_htrans;
    logic [1:0][2:0]  m_hsize;
    logic [1:0]       m_hwrite;
    logic [1:0][31:0] m_hwdata;
    logic [1:0]       m_hready;

    assign m_haddr  = {M1_HADDR,  M0_HADDR};
    assign m_htrans = {M1_HTRANS, M0_HTRANS};
    assign m_hsize  = {M1_HSIZE,  M0_HSIZE};
    assign m_hwrite = {M1_HWRITE, M0_HWRITE};
    assign m_hwdata = {M1_HWDATA, M0_HWDATA};

    // Arbitration state: address owner, data owner, data-phase valid, data-phase-is-replay.
    logic g_q,  g_d;
    logic d_q,  d_d;
    logic dv_q, dv_d;
    logic rp_q, rp_d;

    // Pending slots and stall flags. The captured HTRANS is not kept because a
    // replay is always presented as NONSEQ.
    logic [1:0]       p_vld_q,   p_vld_d;
    logic [1:0][31:0] p_addr_q,  p_addr_d;
    logic [1:0][2:0]  p_size_q,  p_size_d;
    logic [1:0]       p_write_q, p_write_d;
    logic [1:0]       w_q,       w_d;

    logic [1:0] req;
    logic       g_sel;

    // Address-phase mux: the granted master's pending slot wins over its live signals.
    always_comb begin
        if (p_vld_q[g_q]) begin
            HADDR  = p_addr_q[g_q];
            HTRANS = TRANS_NONSEQ;
            HSIZE  = p_size_q[g_q];
            HWRITE = p_write_q[g_q];
        end else begin
            HADDR  = m_haddr[g_q];
            HTRANS = m_htrans[g_q];
            HSIZE  = m_hsize[g_q];
            HWRITE = m_hwrite[g_q];
        end
    end

    assign HWDATA    = m_hwdata[d_q];
    assign M0_HRDATA = HRDATA;
    assign M1_HRDATA = HRDATA;
    assign M0_HREADY = m_hready[0];
    assign M1_HREADY = m_hready[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            assign req[gi] = p_vld_q[gi] | m_htrans[gi][1];

            // Ready per master: a stalled master is released only when its replay data phase completes.
            always_comb begin
                if (w_q[gi]) begin
                    m_hready[gi] = (d_q == 1'(gi)) & dv_q & rp_q & HREADY;
                end else if (g_q == 1'(gi)) begin
                    m_hready[gi] = HREADY;
                end else if ((d_q == 1'(gi)) && dv_q) begin
                    m_hready[gi] = HREADY;
                end else begin
                    m_hready[gi] = 1'b1;
                end
            end
        end
    endgenerate

    // Next-owner selection for the arbitration policy.
    always_comb begin
`ifdef AHBL_ARB_RR_EN
        g_sel = req[~g_q] ? ~g_q : g_q;
`else
        g_sel = req[0] ? 1'b0 : (req[1] ? 1'b1 : g_q);
`endif
    end

    // Next-state: bus accept, grant update, stall release and capture of non-granted masters.
    always_comb begin
        g_d       = g_q;
        d_d       = d_q;
        dv_d      = dv_q;
        rp_d      = rp_q;
        p_vld_d   = p_vld_q;
        p_addr_d  = p_addr_q;
        p_size_d  = p_size_q;
        p_write_d = p_write_q;
        w_d       = w_q;

        if (HREADY) begin
            if (HTRANS[1]) begin
                d_d            = g_q;
                dv_d           = 1'b1;
                rp_d           = p_vld_q[g_q];
                p_vld_d[g_q]   = 1'b0;
            end else begin
                dv_d = 1'b0;
            end
            // Bursts stay intact on the bus: no re-arbitration mid-burst.
            if (HTRANS != TRANS_SEQ && HTRANS != TRANS_BUSY) begin
                g_d = g_sel;
            end
        end

        for (int i = 0; i < 2; i++) begin
            if (w_q[i] && (d_q == i[0]) && dv_q && rp_q && HREADY) begin
                w_d[i] = 1'b0;
            end
            if ((g_q != i[0]) && m_hready[i] && m_htrans[i][1] && !p_vld_q[i]) begin
                p_vld_d[i]   = 1'b1;
                p_addr_d[i]  = m_haddr[i];
                p_size_d[i]  = m_hsize[i];
                p_write_d[i] = m_hwrite[i];
                w_d[i]       = 1'b1;
            end
        end
    end

    // State registers; reset drops any pending transfer without replaying it.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            g_q       <= 1'b0;
            d_q       <= 1'b0;
            dv_q      <= 1'b0;
            rp_q      <= 1'b0;
            p_vld_q   <= '0;
            p_addr_q  <= '0;
            p_size_q  <= '0;
            p_write_q <= '0;
            w_q       <= '0;
        end else begin
            g_q       <= g_d;
            d_q       <= d_d;
            dv_q      <= dv_d;
            rp_q      <= rp_d;
            p_vld_q   <= p_vld_d;
            p_addr_q  <= p_addr_d;
            p_size_q  <= p_size_d;
            p_write_q <= p_write_d;
            w_q       <= w_d;
        end
    end

    // Keep the idle encoding referenced for readers of the mux above.
    logic unused_idle;
    assign unused_idle = (TRANS_IDLE == 2'b00);

endmodule
